frame_disassembly: RTL and testbench

Receive-side counterpart of the fpga1 frame assembler. Accepts the recovered serial bit stream one bit per `vin` strobe and hunts for the sync word. Once aligned, it extracts each 28-bit payload and its parity bit, then presents the payload as a parallel word with a one-cycle valid pulse. It tracks frame alignment with a miss-tolerant flywheel and reports lock state.

---
 rtl/frame_pkg.sv | 25 ++
 rtl/frame_disassembly_sync_detect.sv | 28 ++
 rtl/frame_disassembly.sv | 149 ++++++++++++++
 tb/tb_frame_disassembly.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared framing definitions for the frame assembler and frame_disassembly.
package frame_pkg;

  localparam int unsigned SYNC_W   = 8;
  localparam int unsigned DATA_W   = 28;
  localparam int unsigned FRAME_W  = SYNC_W + DATA_W + 1;
  localparam int unsigned MISS_MAX = 2;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned MISS_W   = $clog2(MISS_MAX + 1);

  localparam logic [SYNC_W-1:0] SYNC_WORD = 8'hE4;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    PARITY  = 2'd2,
    SYNC    = 2'd3
  } frame_rx_state_t;

  // Even-parity bit that makes popcount(data) + bit even.
  function automatic logic frame_parity(input logic [DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/frame_disassembly_sync_detect.sv
// SYNC_W-bit serial shift register with a look-ahead match on the incoming bit.
module sync_detect
  import frame_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic match_c
);

  logic [SYNC_W-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (clr) begin
      sr <= '0;
    end else if (en) begin
      sr <= {sr[SYNC_W-2:0], din};
    end
  end

  // True when the word including the bit being sampled now equals the sync word.
  assign match_c = ({sr[SYNC_W-2:0], din} == SYNC_WORD);

endmodule

// File: rtl/frame_disassembly.sv
// Serial frame receiver: sync hunt, payload extraction and flywheel lock tracking.
// Optional parity checking is enabled by defining FRAME_DISASSEMBLY_PARITY_EN.
module frame_disassembly
  import frame_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              vin,
  output logic [DATA_W-1:0] dout,
  output logic              vout,
  output logic              locked,
  output logic              parity_err
);

  frame_rx_state_t   state, state_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [MISS_W-1:0] miss_cnt, miss_cnt_n;
  logic              deliver, deliver_n;
  logic [DATA_W-1:0] payload, payload_n;
  logic              par_acc, par_acc_n;
  logic [DATA_W-1:0] dout_n;
  logic              vout_n, locked_n, parity_err_n;
  logic              sync_clr;
  logic              sync_match;

  sync_detect u_sync_detect (
    .clk     (clk),
    .rst     (rst),
    .en      (vin),
    .clr     (sync_clr),
    .din     (din),
    .match_c (sync_match)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      bit_cnt    <= '0;
      miss_cnt   <= '0;
      deliver    <= 1'b0;
      payload    <= '0;
      par_acc    <= 1'b0;
      dout       <= '0;
      vout       <= 1'b0;
      locked     <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      miss_cnt   <= miss_cnt_n;
      deliver    <= deliver_n;
      payload    <= payload_n;
      par_acc    <= par_acc_n;
      dout       <= dout_n;
      vout       <= vout_n;
      locked     <= locked_n;
      parity_err <= parity_err_n;
    end
  end

  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    miss_cnt_n   = miss_cnt;
    deliver_n    = deliver;
    payload_n    = payload;
    par_acc_n    = par_acc;
    dout_n       = dout;
    vout_n       = 1'b0;
    locked_n     = locked;
    parity_err_n = 1'b0;
    sync_clr     = 1'b0;

    if (vin) begin
      unique case (state)
        HUNT: begin
          if (sync_match) begin
            state_n    = PAYLOAD;
            bit_cnt_n  = '0;
            miss_cnt_n = '0;
            deliver_n  = 1'b1;
            par_acc_n  = 1'b0;
          end
        end

        PAYLOAD: begin
          payload_n = {payload[DATA_W-2:0], din};
          par_acc_n = par_acc ^ din;
          if (bit_cnt == CNT_W'(DATA_W - 1)) begin
            state_n   = PARITY;
            bit_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt + CNT_W'(1);
          end
        end

        PARITY: begin
`ifdef FRAME_DISASSEMBLY_PARITY_EN
          if (deliver) begin
            if (par_acc ^ din) begin
              parity_err_n = 1'b1;
            end else begin
              vout_n = 1'b1;
              dout_n = payload;
            end
          end
`else
          if (deliver) begin
            vout_n = 1'b1;
            dout_n = payload;
          end
`endif
          par_acc_n = 1'b0;
          bit_cnt_n = '0;
          state_n   = SYNC;
        end

        SYNC: begin
          // Frame-aligned check: the detector holds exactly the sync slot on its last bit.
          if (bit_cnt == CNT_W'(SYNC_W - 1)) begin
            bit_cnt_n = '0;
            if (sync_match) begin
              miss_cnt_n = '0;
              locked_n   = 1'b1;
              deliver_n  = 1'b1;
              state_n    = PAYLOAD;
            end else if (32'(miss_cnt) + 32'd1 < MISS_MAX) begin
              miss_cnt_n = miss_cnt + MISS_W'(1);
              deliver_n  = 1'b0;
              state_n    = PAYLOAD;
            end else begin
              miss_cnt_n = '0;
              locked_n   = 1'b0;
              deliver_n  = 1'b0;
              sync_clr   = 1'b1;
              state_n    = HUNT;
            end
          end else begin
            bit_cnt_n = bit_cnt + CNT_W'(1);
          end
        end

        default: state_n = HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_disassembly.sv
// Directed and randomized bench for frame_disassembly against a frame-position model.
module tb_frame_disassembly;

  logic        clk = 1'b0;
  logic        rst;
  logic        din;
  logic        vin;
  logic [27:0] dout;
  logic        vout;
  logic        locked;
  logic        parity_err;

  frame_disassembly dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .vin        (vin),
    .dout       (dout),
    .vout       (vout),
    .locked     (locked),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

`ifdef FRAME_DISASSEMBLY_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif
  localparam int M_MISS_MAX = 2;
  localparam logic [7:0] M_SYNC = 8'hE4;

  int vectors = 0;
  int miscompares = 0;
  int vout_seen = 0;
  int perr_seen = 0;

  // Reference model: position within the 37-bit frame once aligned.
  bit          m_aligned;
  int          m_fi;
  int          m_miss;
  bit          m_deliver;
  logic [7:0]  m_hist;
  logic [7:0]  m_sync;
  logic [27:0] m_payload;
  logic [27:0] exp_dout;
  logic        exp_vout, exp_locked, exp_perr;

  function automatic void model_reset();
    m_aligned = 1'b0; m_fi = 0; m_miss = 0; m_deliver = 1'b0;
    m_hist = '0; m_sync = '0; m_payload = '0;
    exp_dout = '0; exp_vout = 1'b0; exp_locked = 1'b0; exp_perr = 1'b0;
  endfunction

  function automatic void model_bit(input logic b);
    if (!m_aligned) begin
      m_hist = {m_hist[6:0], b};
      if (m_hist == M_SYNC) begin
        m_aligned = 1'b1; m_fi = 0; m_deliver = 1'b1; m_miss = 0;
      end
    end else begin
      if (m_fi < 28) begin
        m_payload = {m_payload[26:0], b};
      end else if (m_fi == 28) begin
        if (m_deliver) begin
          if (PARITY_EN && ((($countones(m_payload) + int'(b)) % 2) != 0)) exp_perr = 1'b1;
          else begin
            exp_vout = 1'b1;
            exp_dout = m_payload;
          end
        end
      end else begin
        m_sync = {m_sync[6:0], b};
        if (m_fi == 36) begin
          if (m_sync == M_SYNC) begin
            m_miss = 0; exp_locked = 1'b1; m_deliver = 1'b1;
          end else begin
            m_miss++;
            m_deliver = 1'b0;
            if (m_miss >= M_MISS_MAX) begin
              m_aligned = 1'b0; m_hist = '0; m_miss = 0; exp_locked = 1'b0;
            end
          end
        end
      end
      m_fi = (m_fi + 1) % 37;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    check("dout", 32'(dout), 32'(exp_dout));
    check("vout", 32'(vout), 32'(exp_vout));
    check("locked", 32'(locked), 32'(exp_locked));
    check("parity_err", 32'(parity_err), 32'(exp_perr));
  endtask

  // One clock: drive at the negedge, let the posedge sample, check at the next negedge.
  task automatic cyc(input logic b, input logic v);
    din = b;
    vin = v;
    exp_vout = 1'b0;
    exp_perr = 1'b0;
    if (v) model_bit(b);
    @(negedge clk);
    check_outputs();
    if (vout === 1'b1) vout_seen++;
    if (parity_err === 1'b1) perr_seen++;
  endtask

  task automatic send_bits(input logic [36:0] bits, input int n, input int gap, input bit rnd);
    for (int i = n - 1; i >= 0; i--) begin
      int g;
      g = rnd ? int'($urandom_range(0, gap)) : gap;
      repeat (g) cyc(1'($urandom), 1'b0);
      cyc(bits[i], 1'b1);
    end
  endtask

  task automatic send_frame(input logic [7:0] s, input logic [27:0] d, input logic p,
                            input int gap, input bit rnd);
    send_bits({s, d, p}, 37, gap, rnd);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    for (int i = 0; i < n; i++) begin
      din = 1'($urandom);
      vin = 1'($urandom);
      @(negedge clk);
      check_outputs();
    end
    rst = 1'b0;
    vin = 1'b0;
  endtask

  int base_v;
  int base_p;

  initial begin
    rst = 1'b1; din = 1'b0; vin = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset holds everything low while inputs toggle.
    do_reset(6);

    // Single frame at full rate: delivered, not yet locked.
    base_v = vout_seen;
    send_frame(8'hE4, 28'hABCDEF1, 1'b0, 0, 1'b0);
    check("single_vout_count", 32'(vout_seen - base_v), 32'd1);
    check("single_dout", 32'(dout), 32'h0ABCDEF1);
    check("single_locked", 32'(locked), 32'd0);

    // Lock acquisition with vin every third cycle.
    do_reset(2);
    base_v = vout_seen;
    send_frame(8'hE4, 28'h0000001, 1'b1, 2, 1'b0);
    check("gap_first_dout", 32'(dout), 32'h00000001);
    check("gap_locked_early", 32'(locked), 32'd0);
    send_frame(8'hE4, 28'h5555555, 1'b0, 2, 1'b0);
    check("gap_vout_count", 32'(vout_seen - base_v), 32'd2);
    check("gap_second_dout", 32'(dout), 32'h05555555);
    check("gap_locked", 32'(locked), 32'd1);

    // Flywheel: one bad sync discards a frame but keeps lock; a second drops it.
    base_v = vout_seen;
    send_frame(8'hE5, 28'h0000000, 1'b0, 0, 1'b0);
    check("fly_discard", 32'(vout_seen - base_v), 32'd0);
    check("fly_still_locked", 32'(locked), 32'd1);
    send_frame(8'hE5, 28'h0000000, 1'b0, 0, 1'b0);
    check("fly_lost_lock", 32'(locked), 32'd0);
    check("fly_no_vout", 32'(vout_seen - base_v), 32'd0);
    send_frame(8'hE4, 28'h1234567, ^28'h1234567, 0, 1'b0);
    send_frame(8'hE4, 28'h7654321, ^28'h7654321, 0, 1'b0);
    check("fly_reacquire_vout", 32'(vout_seen - base_v), 32'd2);
    check("fly_relocked", 32'(locked), 32'd1);
    check("fly_dout", 32'(dout), 32'h07654321);

    // Bad parity on a deliverable frame.
    do_reset(2);
    base_v = vout_seen;
    base_p = perr_seen;
    send_frame(8'hE4, 28'h0000001, 1'b0, 0, 1'b0);
    if (PARITY_EN) begin
      check("par_err_count", 32'(perr_seen - base_p), 32'd1);
      check("par_vout_count", 32'(vout_seen - base_v), 32'd0);
      check("par_dout_held", 32'(dout), 32'd0);
    end else begin
      check("par_err_count", 32'(perr_seen - base_p), 32'd0);
      check("par_vout_count", 32'(vout_seen - base_v), 32'd1);
      check("par_dout", 32'(dout), 32'h00000001);
    end

    // Reset after 14 payload bits, then a clean frame.
    do_reset(2);
    base_v = vout_seen;
    send_bits({29'd0, 8'hE4}, 8, 0, 1'b0);
    send_bits({23'd0, 14'h2AF3}, 14, 0, 1'b0);
    #2;
    do_reset(3);
    check("midrst_no_vout", 32'(vout_seen - base_v), 32'd0);
    send_frame(8'hE4, 28'hABCDEF1, 1'b0, 0, 1'b0);
    check("midrst_vout", 32'(vout_seen - base_v), 32'd1);
    check("midrst_dout", 32'(dout), 32'h0ABCDEF1);

    // Randomized frames: corrupted syncs, bad parity, junk bits and random gaps.
    do_reset(2);
    for (int f = 0; f < 60; f++) begin
      logic [7:0]  s;
      logic [27:0] d;
      logic        p;
      s = 8'hE4;
      if ($urandom_range(0, 3) == 0) s = s ^ (8'h01 << $urandom_range(0, 7));
      d = 28'($urandom);
      p = ^d;
      if ($urandom_range(0, 4) == 0) p = ~p;
      if ($urandom_range(0, 9) == 0) send_bits(37'($urandom), int'($urandom_range(1, 5)), 1, 1'b1);
      send_frame(s, d, p, int'($urandom_range(0, 3)), 1'b1);
    end
    repeat (4) cyc(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
